register_file_param: RTL and testbench
======================================

Name: register_file_param

Overview:
Parametrised register file with synchronous, single-clock operation.
- One write port and two registered read ports (A, B).
- Write-first bypass from write port to read ports.
- Optional hardwired-zero register 0.
- Per-register pending-write scoreboard (busy bits) for datapath hazard detection.
- Sits between the decode stage and the ALU operand latches.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, 1 = register 0 always reads 0, writes and marks to it ignored

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- WR  in  1  write enable
- RegSelect  in  ADDR_W  write address
- IN  in  DATA_W  write data
- MARK  in  1  set busy bit of MarkSelect (destination issued, result pending)
- MarkSelect  in  ADDR_W  scoreboard address to mark
- REA  in  1  read enable, port A
- ASelect  in  ADDR_W  read address, port A
- REB  in  1  read enable, port B
- BSelect  in  ADDR_W  read address, port B
- OUTA  out  DATA_W  registered read data, port A
- OUTB  out  DATA_W  registered read data, port B
- VALIDA  out  1  OUTA updated this cycle
- VALIDB  out  1  OUTB updated this cycle
- BUSYA  out  1  registered busy flag of ASelect
- BUSYB  out  1  registered busy flag of BSelect

Behaviour:
Clock, reset and interface rules:
- Single clock domain; reset is synchronous and active-high, and takes priority over all other inputs.
- Reset (sampled at posedge): all DEPTH registers = 0, all busy bits = 0, OUTA/OUTB = 0, VALIDA/VALIDB/BUSYA/BUSYB = 0.
- Reset asserted mid-operation: any write, mark or read presented in the same cycle is discarded.

Write port:
- At posedge with WR=1: mem[RegSelect] <= IN, and busy[RegSelect] cleared.
- ZERO_REG=1 and RegSelect=0: write ignored.

Scoreboard:
- At posedge with MARK=1: busy[MarkSelect] set.
- ZERO_REG=1 and MarkSelect=0: mark ignored.
- WR and MARK to the same address in one cycle: mark wins; data is written and busy ends at 1 (a new producer has issued).

Read ports (A and B are identical and independent):
- Latency 1 cycle. At posedge with REA=1, OUTA <= data for ASelect, where data is:
  - 0 if ZERO_REG=1 and ASelect=0;
  - else IN if WR=1 and RegSelect==ASelect (write-first bypass);
  - else mem[ASelect].
- VALIDA <= REA.
- BUSYA <= next-state busy[ASelect]. This reflects that cycle's clear and mark, so it is 0 for ZERO_REG reg0.
- REA=0: OUTA and BUSYA hold their previous values; VALIDA = 0.
- Both ports may read the same address, including the address being written, in one cycle. Both get identical data.

Boundaries:
- Addresses 0 and DEPTH-1 are both valid; no wrap or decode gaps.
- IN is stored unmodified; no truncation, since width = DATA_W.

Implementation constraints:
- Storage is a flip-flop array (no RAM inference required).
- All outputs are registered.

Optional Feature:
Macro: REGFILE_DEBUG_FLAT_EN
- Defined: adds output port DBG_FLAT, width DEPTH*DATA_W.
  - Bits [i*DATA_W +: DATA_W] = mem[i], driven directly from the storage flops with no extra latency.
  - With ZERO_REG=1, slice 0 reads 0.
  - Purpose: lab display and testbench visibility of every register.
- Undefined: DBG_FLAT port does not exist; no other behaviour changes.

Test Plan:
1. Reset, then REA=1/REB=1 at ASelect=3/BSelect=15 for one cycle -> next cycle OUTA=0x0000, OUTB=0x0000, VALIDA=VALIDB=1, BUSYA=BUSYB=0.
2. WR=1, RegSelect=5, IN=0xBEEF. Next cycle REA=1, ASelect=5 -> OUTA=0xBEEF one cycle later. REA=0 for the following 3 cycles -> OUTA holds 0xBEEF, VALIDA=0.
3. Same-cycle bypass: WR=1, RegSelect=7, IN=0x1234, REA=1, ASelect=7, REB=1, BSelect=7 -> next cycle OUTA=OUTB=0x1234.
4. ZERO_REG=1: WR=1, RegSelect=0, IN=0xFFFF, then read A at 0 -> OUTA=0x0000. MARK at 0 -> BUSYA=0.
5. Scoreboard: MARK=1, MarkSelect=9; read A at 9 -> BUSYA=1. Then WR=1, RegSelect=9, IN=0x00AA, with REA=1, ASelect=9 in the same cycle -> OUTA=0x00AA, BUSYA=0. Repeat with MARK=1, MarkSelect=9 in the write cycle -> BUSYA=1.
6. Fill all 16 registers with 0x1000+i, assert reset with WR=1, RegSelect=2, IN=0x5555 in the same cycle -> all registers 0, OUTA/OUTB=0. With REGFILE_DEBUG_FLAT_EN defined -> DBG_FLAT=0 after reset; before reset DBG_FLAT slice 15 = 0x100F.

Source files
------------

// File: rtl/register_file_param_if.sv
// register_file_param_if: write, mark and dual read-port signals of the register file.
interface register_file_param_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              WR;
   logic [ADDR_W-1:0] RegSelect;
   logic [DATA_W-1:0] IN;
   logic              MARK;
   logic [ADDR_W-1:0] MarkSelect;
   logic              REA;
   logic [ADDR_W-1:0] ASelect;
   logic              REB;
   logic [ADDR_W-1:0] BSelect;
   logic [DATA_W-1:0] OUTA;
   logic [DATA_W-1:0] OUTB;
   logic              VALIDA;
   logic              VALIDB;
   logic              BUSYA;
   logic              BUSYB;
   modport master (
      output WR, RegSelect, IN, MARK, MarkSelect, REA, ASelect, REB, BSelect,
      input  OUTA, OUTB, VALIDA, VALIDB, BUSYA, BUSYB
   );
   modport slave (
      input  WR, RegSelect, IN, MARK, MarkSelect, REA, ASelect, REB, BSelect,
      output OUTA, OUTB, VALIDA, VALIDB, BUSYA, BUSYB
   );
endinterface

// File: rtl/register_file_param.sv
// register_file_param: flop register file, 1 write / 2 registered read ports, write-first bypass, busy scoreboard.
// Optional REGFILE_DEBUG_FLAT_EN exposes every register on DBG_FLAT.
module register_file_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input logic clock,
   input logic reset,
   register_file_param_if.slave bus
`ifdef REGFILE_DEBUG_FLAT_EN
   ,
   output logic [(2**ADDR_W)*DATA_W-1:0] DBG_FLAT
`endif
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy, busy_nxt;
   logic              wr_ok, mk_ok;
   logic [DATA_W-1:0] data_a, data_b;
   assign wr_ok = bus.WR && !(ZERO_REG != 0 && bus.RegSelect == '0);
   assign mk_ok = bus.MARK && !(ZERO_REG != 0 && bus.MarkSelect == '0);
   assign data_a = (ZERO_REG != 0 && bus.ASelect == '0) ? '0 :
                   (wr_ok && bus.RegSelect == bus.ASelect) ? bus.IN : mem[bus.ASelect];
   assign data_b = (ZERO_REG != 0 && bus.BSelect == '0) ? '0 :
                   (wr_ok && bus.RegSelect == bus.BSelect) ? bus.IN : mem[bus.BSelect];
   // mark is applied after clear so a same-cycle reissue leaves the register busy
   always_comb begin
      busy_nxt = busy;
      if (wr_ok) busy_nxt[bus.RegSelect] = 1'b0;
      if (mk_ok) busy_nxt[bus.MarkSelect] = 1'b1;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         busy       <= '0;
         bus.OUTA   <= '0;
         bus.OUTB   <= '0;
         bus.VALIDA <= 1'b0;
         bus.VALIDB <= 1'b0;
         bus.BUSYA  <= 1'b0;
         bus.BUSYB  <= 1'b0;
      end else begin
         if (wr_ok) mem[bus.RegSelect] <= bus.IN;
         busy       <= busy_nxt;
         bus.VALIDA <= bus.REA;
         bus.VALIDB <= bus.REB;
         if (bus.REA) begin
            bus.OUTA  <= data_a;
            bus.BUSYA <= busy_nxt[bus.ASelect];
         end
         if (bus.REB) begin
            bus.OUTB  <= data_b;
            bus.BUSYB <= busy_nxt[bus.BSelect];
         end
      end
   end
`ifdef REGFILE_DEBUG_FLAT_EN
   for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign DBG_FLAT[i*DATA_W +: DATA_W] = mem[i];
   end
`endif
endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: random and directed stimulus on ZERO_REG=0 and ZERO_REG=1 instances against an array model.
module tb_register_file_param;
   logic        clock = 1'b0;
   logic        reset, WR, MARK, REA, REB;
   logic [3:0]  RegSelect, MarkSelect, ASelect, BSelect;
   logic [15:0] IN;
   int          vectors = 0, miscompares = 0;
   bit          model_live = 1'b0;
   always #5 clock = ~clock;

   register_file_param_if #(.DATA_W(16), .ADDR_W(4)) b0 ();
   register_file_param_if #(.DATA_W(16), .ADDR_W(4)) b1 ();
   assign b0.WR = WR;               assign b1.WR = WR;
   assign b0.RegSelect = RegSelect; assign b1.RegSelect = RegSelect;
   assign b0.IN = IN;               assign b1.IN = IN;
   assign b0.MARK = MARK;           assign b1.MARK = MARK;
   assign b0.MarkSelect = MarkSelect; assign b1.MarkSelect = MarkSelect;
   assign b0.REA = REA;             assign b1.REA = REA;
   assign b0.ASelect = ASelect;     assign b1.ASelect = ASelect;
   assign b0.REB = REB;             assign b1.REB = REB;
   assign b0.BSelect = BSelect;     assign b1.BSelect = BSelect;

`ifdef REGFILE_DEBUG_FLAT_EN
   logic [255:0] flat0, flat1;
   register_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) u0 (.clock(clock), .reset(reset), .bus(b0), .DBG_FLAT(flat0));
   register_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u1 (.clock(clock), .reset(reset), .bus(b1), .DBG_FLAT(flat1));
`else
   register_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) u0 (.clock(clock), .reset(reset), .bus(b0));
   register_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u1 (.clock(clock), .reset(reset), .bus(b1));
`endif

   // model: index 0 is the plain file, index 1 the hardwired-zero file
   logic [15:0] mm [2][16];
   logic [15:0] mb [2];
   logic [15:0] ea [2], eb [2];
   logic        eva [2], evb [2], eba [2], ebb [2];

   always @(posedge clock) begin
      for (int z = 0; z < 2; z++) begin
         if (reset) begin
            for (int r = 0; r < 16; r++) mm[z][r] = 16'h0;
            mb[z] = 16'h0; ea[z] = 16'h0; eb[z] = 16'h0;
            eva[z] = 1'b0; evb[z] = 1'b0; eba[z] = 1'b0; ebb[z] = 1'b0;
         end else begin
            logic        wz, mz;
            logic [15:0] nb;
            wz = WR && !(z == 1 && RegSelect == 4'd0);
            mz = MARK && !(z == 1 && MarkSelect == 4'd0);
            nb = mb[z];
            if (wz) nb[RegSelect] = 1'b0;
            if (mz) nb[MarkSelect] = 1'b1;
            if (REA) begin
               ea[z]  = (z == 1 && ASelect == 4'd0) ? 16'h0 : (wz && RegSelect == ASelect) ? IN : mm[z][ASelect];
               eba[z] = nb[ASelect];
            end
            if (REB) begin
               eb[z]  = (z == 1 && BSelect == 4'd0) ? 16'h0 : (wz && RegSelect == BSelect) ? IN : mm[z][BSelect];
               ebb[z] = nb[BSelect];
            end
            eva[z] = REA;
            evb[z] = REB;
            if (wz) mm[z][RegSelect] = IN;
            mb[z] = nb;
         end
      end
      if (reset) model_live = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      if (!model_live) return;
      chk("u0.OUTA", {16'h0, b0.OUTA}, {16'h0, ea[0]});
      chk("u0.OUTB", {16'h0, b0.OUTB}, {16'h0, eb[0]});
      chk("u0.flags", {28'h0, b0.VALIDA, b0.VALIDB, b0.BUSYA, b0.BUSYB}, {28'h0, eva[0], evb[0], eba[0], ebb[0]});
      chk("u1.OUTA", {16'h0, b1.OUTA}, {16'h0, ea[1]});
      chk("u1.OUTB", {16'h0, b1.OUTB}, {16'h0, eb[1]});
      chk("u1.flags", {28'h0, b1.VALIDA, b1.VALIDB, b1.BUSYA, b1.BUSYB}, {28'h0, eva[1], evb[1], eba[1], ebb[1]});
`ifdef REGFILE_DEBUG_FLAT_EN
      for (int r = 0; r < 16; r++) begin
         chk("u0.DBG_FLAT", {16'h0, flat0[r*16 +: 16]}, {16'h0, mm[0][r]});
         chk("u1.DBG_FLAT", {16'h0, flat1[r*16 +: 16]}, {16'h0, mm[1][r]});
      end
`endif
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      compare_all();
   endtask

   task automatic idle();
      reset = 1'b0; WR = 1'b0; MARK = 1'b0; REA = 1'b0; REB = 1'b0;
      RegSelect = 4'd0; MarkSelect = 4'd0; ASelect = 4'd0; BSelect = 4'd0; IN = 16'h0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      step(); step();
      idle();
      // reset state read
      REA = 1'b1; ASelect = 4'd3; REB = 1'b1; BSelect = 4'd15;
      step(); idle();
      chk("rst OUTA", {16'h0, b0.OUTA}, 32'h0);
      chk("rst OUTB", {16'h0, b0.OUTB}, 32'h0);
      chk("rst flags", {28'h0, b0.VALIDA, b0.VALIDB, b0.BUSYA, b0.BUSYB}, 32'hC);
      // write then read, then hold
      WR = 1'b1; RegSelect = 4'd5; IN = 16'hBEEF;
      step(); idle();
      REA = 1'b1; ASelect = 4'd5;
      step(); idle();
      chk("rd5 OUTA", {16'h0, b0.OUTA}, 32'hBEEF);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold OUTA", {16'h0, b0.OUTA}, 32'hBEEF);
         chk("hold VALIDA", {31'h0, b0.VALIDA}, 32'h0);
      end
      // same-cycle bypass to both ports
      WR = 1'b1; RegSelect = 4'd7; IN = 16'h1234; REA = 1'b1; ASelect = 4'd7; REB = 1'b1; BSelect = 4'd7;
      step(); idle();
      chk("byp OUTA", {16'h0, b0.OUTA}, 32'h1234);
      chk("byp OUTB", {16'h0, b0.OUTB}, 32'h1234);
      chk("byp u1 OUTA", {16'h0, b1.OUTA}, 32'h1234);
      // register 0 behaviour with and without hardwired zero
      WR = 1'b1; RegSelect = 4'd0; IN = 16'hFFFF;
      step(); idle();
      REA = 1'b1; ASelect = 4'd0;
      step(); idle();
      chk("z1 OUTA r0", {16'h0, b1.OUTA}, 32'h0);
      chk("z0 OUTA r0", {16'h0, b0.OUTA}, 32'hFFFF);
      MARK = 1'b1; MarkSelect = 4'd0; REA = 1'b1; ASelect = 4'd0;
      step(); idle();
      chk("z1 BUSYA r0", {31'h0, b1.BUSYA}, 32'h0);
      chk("z0 BUSYA r0", {31'h0, b0.BUSYA}, 32'h1);
      // scoreboard mark / clear / reissue
      MARK = 1'b1; MarkSelect = 4'd9;
      step(); idle();
      REA = 1'b1; ASelect = 4'd9;
      step(); idle();
      chk("sb mark", {31'h0, b0.BUSYA}, 32'h1);
      WR = 1'b1; RegSelect = 4'd9; IN = 16'h00AA; REA = 1'b1; ASelect = 4'd9;
      step(); idle();
      chk("sb clr OUTA", {16'h0, b0.OUTA}, 32'h00AA);
      chk("sb clr BUSYA", {31'h0, b0.BUSYA}, 32'h0);
      WR = 1'b1; RegSelect = 4'd9; IN = 16'h00AA; MARK = 1'b1; MarkSelect = 4'd9; REA = 1'b1; ASelect = 4'd9;
      step(); idle();
      chk("sb reissue BUSYA", {31'h0, b0.BUSYA}, 32'h1);
      // random traffic, narrow address ranges encourage collisions
      for (int n = 0; n < 3000; n++) begin
         int hi;
         hi = ($urandom_range(0, 3) == 0) ? 15 : 3;
         reset = ($urandom_range(0, 99) == 0);
         WR = 1'($urandom_range(0, 1)); MARK = 1'($urandom_range(0, 2) == 0);
         REA = 1'($urandom_range(0, 1)); REB = 1'($urandom_range(0, 1));
         RegSelect = 4'($urandom_range(0, hi)); MarkSelect = 4'($urandom_range(0, hi));
         ASelect = 4'($urandom_range(0, hi)); BSelect = 4'($urandom_range(0, hi));
         IN = 16'($urandom);
         step();
      end
      idle();
      // fill all, then reset colliding with a write
      for (int r = 0; r < 16; r++) begin
         WR = 1'b1; RegSelect = 4'(r); IN = 16'h1000 + 16'(r);
         step();
      end
      idle();
`ifdef REGFILE_DEBUG_FLAT_EN
      chk("flat15 pre", {16'h0, flat0[15*16 +: 16]}, 32'h100F);
`endif
      REA = 1'b1; ASelect = 4'd15; REB = 1'b1; BSelect = 4'd2;
      step(); idle();
      chk("fill OUTA", {16'h0, b0.OUTA}, 32'h100F);
      reset = 1'b1; WR = 1'b1; RegSelect = 4'd2; IN = 16'h5555; REA = 1'b1; ASelect = 4'd2;
      step(); idle();
      chk("rst OUTA mid", {16'h0, b0.OUTA}, 32'h0);
      chk("rst OUTB mid", {16'h0, b0.OUTB}, 32'h0);
`ifdef REGFILE_DEBUG_FLAT_EN
      chk("flat post", (flat0 == 256'h0) ? 32'h0 : 32'h1, 32'h0);
`endif
      for (int r = 0; r < 16; r++) begin
         REA = 1'b1; ASelect = 4'(r); REB = 1'b1; BSelect = 4'(15 - r);
         step();
         chk("post rst OUTA", {16'h0, b0.OUTA}, 32'h0);
      end
      idle();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
